// File: rtl/rtlola_output_collector.sv
// Sink-side collector for the RTLola monitor: captures each enabled cycle's active
// output streams into a FIFO and serializes them as one record per active stream.
module rtlola_output_collector #(
    parameter int unsigned NUM_STREAMS = 3,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TS_W        = 32,
    parameter int unsigned ID_W        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_STREAMS*DATA_W-1:0] stream_value,
    input  logic [NUM_STREAMS-1:0]        stream_aktv,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [ID_W-1:0]               rec_id,
    output logic [DATA_W-1:0]             rec_value,
    output logic [TS_W-1:0]               rec_ts,
    output logic                          rec_last,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned VEC_W = NUM_STREAMS * DATA_W;

    typedef enum logic {IDLE, EMIT} state_t;

    logic [NUM_STREAMS-1:0] mask_mem [DEPTH];
    logic [VEC_W-1:0]       val_mem  [DEPTH];
    logic [TS_W-1:0]        ts_mem   [DEPTH];

    state_t                 state;
    logic [PTR_W:0]         wr_ptr;
    logic [PTR_W:0]         rd_ptr;
    logic [NUM_STREAMS-1:0] rem_mask;
    logic [TS_W-1:0]        ts;

    logic                   empty;
    logic                   full;
    logic                   fire;
    logic                   pop;
    logic                   capture;
    logic                   push;
    logic [PTR_W:0]         rd_ptr_n;
    logic                   post_pop_empty;
    logic                   sel_valid;
    logic [NUM_STREAMS-1:0] sel_mask;
    logic [VEC_W-1:0]       sel_vals;
    logic [TS_W-1:0]        sel_ts;
    logic [ID_W-1:0]        sel_id;
    logic [DATA_W-1:0]      sel_value;
    logic                   sel_last;

    function automatic logic [ID_W-1:0] low_idx(input logic [NUM_STREAMS-1:0] m);
        low_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (m[i]) low_idx = ID_W'(i);
        end
    endfunction

    // FIFO status and the handshake/push decisions for this cycle
    always_comb begin
        empty          = (wr_ptr == rd_ptr);
        full           = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        fire           = rec_valid && rec_ready;
        pop            = fire && rec_last;
        capture        = en && (|stream_aktv);
        push           = capture && (!full || pop);
        rd_ptr_n       = rd_ptr + (PTR_W+1)'(pop);
        post_pop_empty = (rd_ptr_n == wr_ptr);
    end

    // Choose the entry and remaining mask the serializer presents after this edge;
    // an empty FIFO bypasses the incoming capture so its first record shows next cycle.
    always_comb begin
        sel_valid = 1'b0;
        sel_mask  = '0;
        sel_vals  = '0;
        sel_ts    = '0;
        if (state == EMIT && !pop) begin
            sel_valid = 1'b1;
            sel_mask  = fire ? (rem_mask & (rem_mask - NUM_STREAMS'(1))) : rem_mask;
            sel_vals  = val_mem[rd_ptr[PTR_W-1:0]];
            sel_ts    = ts_mem[rd_ptr[PTR_W-1:0]];
        end else if (!post_pop_empty) begin
            sel_valid = 1'b1;
            sel_mask  = mask_mem[rd_ptr_n[PTR_W-1:0]];
            sel_vals  = val_mem[rd_ptr_n[PTR_W-1:0]];
            sel_ts    = ts_mem[rd_ptr_n[PTR_W-1:0]];
        end else if (push) begin
            sel_valid = 1'b1;
            sel_mask  = stream_aktv;
            sel_vals  = stream_value;
            sel_ts    = ts;
        end
    end

    always_comb begin
        sel_id    = low_idx(sel_mask);
        sel_value = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (sel_id == ID_W'(i)) sel_value = sel_vals[i*DATA_W +: DATA_W];
        end
        sel_last  = (sel_mask != '0) && ((sel_mask & (sel_mask - NUM_STREAMS'(1))) == '0);
    end

    // Storage carries no reset; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mask_mem[wr_ptr[PTR_W-1:0]] <= stream_aktv;
            val_mem[wr_ptr[PTR_W-1:0]]  <= stream_value;
            ts_mem[wr_ptr[PTR_W-1:0]]   <= ts;
        end
    end

    // Serializer state, pointers, counters and registered record outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rem_mask   <= '0;
            ts         <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            rec_valid  <= 1'b0;
            rec_id     <= '0;
            rec_value  <= '0;
            rec_ts     <= '0;
            rec_last   <= 1'b0;
        end else begin
            if (en) ts <= ts + TS_W'(1);
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            rd_ptr <= rd_ptr_n;
            if (capture && !push) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            state     <= sel_valid ? EMIT : IDLE;
            rem_mask  <= sel_mask;
            rec_valid <= sel_valid;
            rec_id    <= sel_id;
            rec_value <= sel_value;
            rec_ts    <= sel_ts;
            rec_last  <= sel_last;
        end
    end

endmodule
